// File: rtl/pkg_cpu.sv
// CPU-side shared types: data access size encoding used on every memory-facing port.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pkg_cpu;

  // One-bit access size: byte or halfword.
  typedef enum logic {
    cpu_data_acc_sz_8  = 1'b0,
    cpu_data_acc_sz_16 = 1'b1
  } cpu_data_acc_sz_e;

endpackage

// File: rtl/pkg_mem_arb.sv
// Memory bus arbiter shared types: FSM state encoding, widths and a saturating counter helper.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pkg_mem_arb;

  localparam int ARB_ST_W  = 2;
  localparam int ARB_CNT_W = 8;

  typedef enum logic [ARB_ST_W-1:0] {
    arb_st_idle   = 2'd0,
    arb_st_access = 2'd1,
    arb_st_ack    = 2'd2
  } arb_st_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_picker.sv
// Two-way winner selection: single requester wins outright; on a tie the locked owner
// keeps the bus, otherwise the non-owner wins (round-robin).
// Latency: combinational. Backpressure: none, evaluated whenever the arbiter is idle.
// Ports: req0/req1 requests, owner last granted index, lock_held owner lock;
//        grant_valid any request present, grant_idx winning requester.
module mem_arb_rr_picker (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  input  logic lock_held,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = lock_held ? owner : ~owner;
    end else begin
      grant_idx = req1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with registered memory-side access and wait timeout.
// Latency: 3 cycles req-to-ack minimum (IDLE, ACCESS, ACK); one access every 3 cycles.
// Backpressure: mem_ready stalls ACCESS; after TIMEOUT stalled cycles the access aborts with err.
// Ports: clk, reset (async active-low); req/addr/wdata/we/sz/lock per requester in;
//        ack/err/rdata per requester out; mem_addr/mem_wdata/mem_we/mem_acc_sz/mem_en out,
//        mem_rdata/mem_ready in; owner = current or last granted requester.
module mem_bus_arbiter
  import pkg_mem_arb::*;
  import pkg_cpu::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  input  logic              sz0,
  input  logic              sz1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_acc_sz,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              owner
);

  localparam logic [ARB_CNT_W-1:0] TIMEOUT_C = ARB_CNT_W'(TIMEOUT);

  arb_st_e              state_q;
  arb_st_e              state_d;
  logic                 owner_q;
  logic                 lock_held_q;
  logic                 err_q;
  logic [ARB_CNT_W-1:0] wait_cnt_q;
  logic [ARB_CNT_W-1:0] wait_cnt_inc;
  logic                 timeout_hit;
  logic                 grant_valid;
  logic                 grant_idx;

  mem_arb_rr_picker u_picker (
    .req0        (req0),
    .req1        (req1),
    .owner       (owner_q),
    .lock_held   (lock_held_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign wait_cnt_inc = sat_inc(wait_cnt_q);
  // Compare the post-increment value so the abort happens on the TIMEOUT-th stalled cycle.
  assign timeout_hit  = (wait_cnt_inc >= TIMEOUT_C);
  assign owner        = owner_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= arb_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      arb_st_idle: begin
        if (grant_valid) begin
          state_d = arb_st_access;
        end
      end
      arb_st_access: begin
        if (mem_ready || timeout_hit) begin
          state_d = arb_st_ack;
        end
      end
      arb_st_ack: begin
        state_d = arb_st_idle;
      end
      default: begin
        state_d = arb_st_idle;
      end
    endcase
  end

  // Outputs: ack/err pulse only for the owner while in ACK.
  always_comb begin
    ack0 = (state_q == arb_st_ack) && !owner_q;
    ack1 = (state_q == arb_st_ack) &&  owner_q;
    err0 = ack0 && err_q;
    err1 = ack1 && err_q;
  end

  // Datapath: memory-side access registers, per-requester read data, arbitration history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_acc_sz  <= cpu_data_acc_sz_16;
      rdata0      <= '0;
      rdata1      <= '0;
      owner_q     <= 1'b1;
      lock_held_q <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        arb_st_idle: begin
          if (grant_valid) begin
            owner_q    <= grant_idx;
            mem_en     <= 1'b1;
            mem_addr   <= grant_idx ? addr1  : addr0;
            mem_wdata  <= grant_idx ? wdata1 : wdata0;
            mem_we     <= grant_idx ? we1    : we0;
            mem_acc_sz <= grant_idx ? sz1    : sz0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
          end
        end
        arb_st_access: begin
          if (mem_ready) begin
            if (owner_q) begin
              rdata1 <= mem_rdata;
            end else begin
              rdata0 <= mem_rdata;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
            // Abort: rdata keeps its previous value.
            if (timeout_hit) begin
              err_q  <= 1'b1;
              mem_en <= 1'b0;
              mem_we <= 1'b0;
            end
          end
        end
        arb_st_ack: begin
          lock_held_q <= owner_q ? lock1 : lock0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic we0 = 1'b0, we1 = 1'b0, sz0 = 1'b1, sz1 = 1'b1, lock0 = 1'b0, lock1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_we, mem_acc_sz, mem_en, owner;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .sz0(sz0), .sz1(sz1),
    .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_acc_sz(mem_acc_sz), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One transaction in flight at most: who owns it, its fields, how many stalled cycles
  // it has seen, and whether it has completed (ack due this cycle).
  bit                t_active, t_done, t_who, t_we, t_sz, t_err;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  int                t_waits;
  bit                m_owner = 1'b1;
  bit                m_lock  = 1'b0;
  logic [DATA_W-1:0] m_rdata [2];
  bit                ack_seen [2];
  bit                m_busy, m_w;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_acc_sz", mem_acc_sz, 1);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_err", {err1, err0}, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_owner", owner, 1);
      t_active = 0; t_done = 0; m_owner = 1; m_lock = 0;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      m_busy = t_active && !t_done;
      chk("mem_en", mem_en, m_busy);
      chk("mem_we", mem_we, m_busy && t_we);
      if (m_busy) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_wdata", mem_wdata, t_wdata);
        chk("mem_acc_sz", mem_acc_sz, t_sz);
      end
      chk("ack0", ack0, t_done && !t_who);
      chk("ack1", ack1, t_done && t_who);
      chk("err0", err0, t_done && !t_who && t_err);
      chk("err1", err1, t_done && t_who && t_err);
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      chk("owner", owner, m_owner);
      // advance to what the next cycle must look like
      if (t_done) begin
        m_lock = t_who ? lock1 : lock0;
        ack_seen[t_who] = 1;
        t_active = 0; t_done = 0;
      end else if (t_active) begin
        if (mem_ready) begin
          m_rdata[t_who] = mem_rdata;
          t_done = 1;
        end else begin
          t_waits++;
          if (t_waits >= TIMEOUT) begin
            t_err = 1; t_done = 1;
          end
        end
      end else if (req0 || req1) begin
        if (req0 && req1) m_w = m_lock ? m_owner : !m_owner;
        else              m_w = req1;
        t_active = 1; t_done = 0; t_err = 0; t_waits = 0;
        t_who = m_w; m_owner = m_w;
        t_addr  = m_w ? addr1  : addr0;
        t_wdata = m_w ? wdata1 : wdata0;
        t_we    = m_w ? we1    : we0;
        t_sz    = m_w ? sz1    : sz0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit pend0, pend1;
  int stall;

  initial begin
    m_rdata[0] = '0; m_rdata[1] = '0;
    ack_seen[0] = 0; ack_seen[1] = 0;
    negs(2);
    chk("lit_reset_owner", owner, 1);
    chk("lit_reset_sz16", mem_acc_sz, 1);
    step(); reset = 1;

    // Single CPU read, ready already high: ack on the third cycle.
    req0 = 1; addr0 = 16'h8010; we0 = 0; sz0 = 1; mem_ready = 1; mem_rdata = 16'hBEEF;
    negs(1); chk("lit_rd_c1_ack0", ack0, 0);
    negs(1); chk("lit_rd_c2_en", mem_en, 1); chk("lit_rd_c2_addr", mem_addr, 16'h8010);
    negs(1); chk("lit_rd_c3_ack0", ack0, 1); chk("lit_rd_c3_rdata0", rdata0, 16'hBEEF);
    chk("lit_rd_c3_err0", err0, 0); chk("lit_rd_c3_ack1", ack1, 0);
    step(); req0 = 0;
    negs(1); chk("lit_rd_idle_ack0", ack0, 0);

    // Fresh reset so requester 0 wins the first tie, then round-robin 0,1,0,1.
    step(); reset = 0;
    step(); reset = 1;
    req0 = 1; req1 = 1; addr1 = 16'h0100; we1 = 0; sz1 = 1;
    for (int k = 0; k < 4; k++) begin
      negs(3);
      chk("lit_rr_ack0", ack0, (k % 2) == 0);
      chk("lit_rr_ack1", ack1, (k % 2) == 1);
    end
    step(); req0 = 0; req1 = 0;

    // Lock: requester 0 keeps the bus once, then releases it to requester 1.
    step(); req0 = 1; req1 = 1; lock0 = 1;
    negs(3); chk("lit_lock_ack0_a", ack0, 1);
    step(); lock0 = 0;
    negs(3); chk("lit_lock_ack0_b", ack0, 1);
    negs(3); chk("lit_lock_ack1", ack1, 1);
    step(); req0 = 0; req1 = 0;

    // Write from requester 1 that never sees mem_ready: aborts after TIMEOUT waits.
    step(); req1 = 1; addr1 = 16'h0040; we1 = 1; wdata1 = 16'h1234; sz1 = 1;
    mem_ready = 0; mem_rdata = 16'h5555;
    negs(2); chk("lit_to_en", mem_en, 1); chk("lit_to_we", mem_we, 1);
    chk("lit_to_wdata", mem_wdata, 16'h1234); chk("lit_to_owner", owner, 1);
    negs(14); chk("lit_to_c16_en", mem_en, 1); chk("lit_to_c16_ack1", ack1, 0);
    negs(1); chk("lit_to_ack1", ack1, 1); chk("lit_to_err1", err1, 1);
    chk("lit_to_en_low", mem_en, 0); chk("lit_to_rdata1", rdata1, 16'hBEEF);
    step(); req1 = 0; we1 = 0;
    negs(1); chk("lit_to_after_ack1", ack1, 0); chk("lit_to_after_en", mem_en, 0);

    // Byte read at odd address with two stalled cycles.
    step(); req0 = 1; addr0 = 16'h0003; we0 = 0; sz0 = 0; mem_ready = 0;
    negs(2); chk("lit_b_c2_sz", mem_acc_sz, 0); chk("lit_b_c2_addr", mem_addr, 16'h0003);
    negs(1); chk("lit_b_c3_sz", mem_acc_sz, 0); chk("lit_b_c3_addr", mem_addr, 16'h0003);
    step(); mem_ready = 1; mem_rdata = 16'h00A5;
    negs(1); chk("lit_b_c4_sz", mem_acc_sz, 0); chk("lit_b_c4_en", mem_en, 1);
    negs(1); chk("lit_b_ack0", ack0, 1); chk("lit_b_rdata0", rdata0, 16'h00A5);
    step(); req0 = 0; sz0 = 1;

    // Reset in the middle of an access: dropped, no ack, next tie goes to 0.
    step(); mem_ready = 0; req0 = 1; req1 = 1; addr0 = 16'h0010; addr1 = 16'h0020;
    negs(2); chk("lit_ra_en", mem_en, 1); chk("lit_ra_owner", owner, 1);
    step(); reset = 0; #1;
    chk("lit_ra_async_en", mem_en, 0); chk("lit_ra_async_ack1", ack1, 0);
    mem_ready = 1;
    negs(1);
    step(); reset = 1;
    negs(1); chk("lit_ra_c1_ack", {ack1, ack0}, 0);
    negs(1); chk("lit_ra_c2_owner", owner, 0); chk("lit_ra_c2_ack1", ack1, 0);
    negs(1); chk("lit_ra_c3_ack0", ack0, 1); chk("lit_ra_c3_ack1", ack1, 0);
    step(); req0 = 0; req1 = 0; mem_ready = 0;

    // Randomized traffic: two well-behaved requesters, stalling memory, rare resets.
    step();
    ack_seen[0] = 0; ack_seen[1] = 0; pend0 = 0; pend1 = 0; stall = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!reset) begin
        reset = 1;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 0; req0 = 0; req1 = 0; pend0 = 0; pend1 = 0;
        ack_seen[0] = 0; ack_seen[1] = 0;
      end else begin
        if (ack_seen[0]) begin ack_seen[0] = 0; pend0 = 0; req0 = 0; end
        if (ack_seen[1]) begin ack_seen[1] = 0; pend1 = 0; req1 = 0; end
        if (!pend0) begin
          if ($urandom_range(0, 2) == 0) begin
            pend0 = 1; req0 = 1;
            addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom);
            we0 = 1'($urandom_range(0, 1)); sz0 = 1'($urandom_range(0, 1));
            lock0 = 1'($urandom_range(0, 1));
          end
        end else if (req0 && t_active && !t_done && !t_who && $urandom_range(0, 7) == 0) begin
          req0 = 0;
        end
        if (!pend1) begin
          if ($urandom_range(0, 2) == 0) begin
            pend1 = 1; req1 = 1;
            addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom);
            we1 = 1'($urandom_range(0, 1)); sz1 = 1'($urandom_range(0, 1));
            lock1 = 1'($urandom_range(0, 1));
          end
        end else if (req1 && t_active && !t_done && t_who && $urandom_range(0, 7) == 0) begin
          req1 = 0;
        end
      end
      if (stall > 0) begin
        stall--;
        mem_ready = 0;
      end else begin
        if ($urandom_range(0, 99) == 0) stall = 20;
        mem_ready = ($urandom_range(0, 2) != 0);
      end
      mem_rdata = DATA_W'($urandom);
    end

    step(); reset = 1; req0 = 0; req1 = 0;
    negs(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
